// File: rtl/arith_pkg.sv
// Shared elaboration-time helpers for the arithmetic primitives
// (adder, subtractor, accumulator).
package arith_pkg;

  function automatic int unsigned max_f(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic int unsigned ceil_div_f(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/subtractor_stage.sv
// One registered slice of the borrow chain: a_i - b_i - borrow_i,
// captured together with its valid bit whenever en is high.
module subtractor_stage #(
  parameter int unsigned CHUNK_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   valid_i,
  input  logic [CHUNK_WIDTH-1:0] a_i,
  input  logic [CHUNK_WIDTH-1:0] b_i,
  input  logic                   borrow_i,
  output logic [CHUNK_WIDTH-1:0] diff_o,
  output logic                   borrow_o,
  output logic                   valid_o
);

  logic [CHUNK_WIDTH:0]   sub_full;
  logic [CHUNK_WIDTH-1:0] diff_d, diff_q;
  logic                   borrow_d, borrow_q;
  logic                   valid_d, valid_q;

  // The extra MSB of the widened difference is the borrow out of this slice.
  always_comb begin
    sub_full = {1'b0, a_i} - {1'b0, b_i} - {{CHUNK_WIDTH{1'b0}}, borrow_i};
    diff_d   = sub_full[CHUNK_WIDTH-1:0];
    borrow_d = sub_full[CHUNK_WIDTH];
    valid_d  = valid_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      diff_q   <= '0;
      borrow_q <= 1'b0;
      valid_q  <= 1'b0;
    end else if (en) begin
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      valid_q  <= valid_d;
    end
  end

  assign diff_o   = diff_q;
  assign borrow_o = borrow_q;
  assign valid_o  = valid_q;

endmodule

// File: rtl/pipelined_subtractor.sv
// Handshaked data1_i - data2_i with the borrow chain split into
// CHUNK_WIDTH slices, one register stage per slice, under a global stall.
module pipelined_subtractor
  import arith_pkg::*;
#(
  parameter int unsigned DATA_WIDTH_1 = 16,
  parameter int unsigned DATA_WIDTH_2 = 16,
  parameter int unsigned CHUNK_WIDTH  = 8
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [DATA_WIDTH_1-1:0]                  data1_i,
  input  logic [DATA_WIDTH_2-1:0]                  data2_i,
  input  logic                                     valid_i,
  output logic                                     ready_o,
  output logic [max_f(DATA_WIDTH_1, DATA_WIDTH_2):0] data_o,
  output logic                                     valid_o,
  input  logic                                     ready_i
);

  localparam int unsigned CW      = CHUNK_WIDTH;
  localparam int unsigned RW      = max_f(DATA_WIDTH_1, DATA_WIDTH_2) + 1;
  localparam int unsigned NSTAGES = ceil_div_f(RW, CW);
  localparam int unsigned PW      = NSTAGES * CW;

  logic              advance;
  logic              in_fire;
  logic [PW-1:0]     a_pad, b_pad, res_full;
  logic [NSTAGES:0]  borrow;
  logic [NSTAGES:0]  vld;
  logic              unused_ok;

  assign advance = ~vld[NSTAGES] | ready_i;
  assign ready_o = advance & ~rst;
  assign in_fire = valid_i & ready_o;
  assign vld[0]    = in_fire;
  assign borrow[0] = 1'b0;

  always_comb begin
    a_pad = '0;
    b_pad = '0;
    a_pad[DATA_WIDTH_1-1:0] = data1_i;
    b_pad[DATA_WIDTH_2-1:0] = data2_i;
  end

  // Stage k sees only the operand slices it and later stages still need
  // (skew) and carries the finished lower result slices alongside (deskew),
  // so every register width shrinks or grows by one chunk per stage.
  for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
    localparam int unsigned OPW = PW - k * CW;

    logic [OPW-1:0]        a_in, b_in;
    logic [CW-1:0]         diff;
    logic [(k+1)*CW-1:0]   res;

    subtractor_stage #(
      .CHUNK_WIDTH(CW)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .en       (advance),
      .valid_i  (vld[k]),
      .a_i      (a_in[CW-1:0]),
      .b_i      (b_in[CW-1:0]),
      .borrow_i (borrow[k]),
      .diff_o   (diff),
      .borrow_o (borrow[k+1]),
      .valid_o  (vld[k+1])
    );

    if (k == 0) begin : g_head
      assign a_in = a_pad;
      assign b_in = b_pad;
      assign res  = diff;
    end else begin : g_body
      localparam int unsigned PREVW = OPW + CW;

      logic [OPW-1:0]    a_d, a_q, b_d, b_q;
      logic [k*CW-1:0]   res_d, res_q;

      always_comb begin
        a_d   = g_stage[k-1].a_in[PREVW-1:CW];
        b_d   = g_stage[k-1].b_in[PREVW-1:CW];
        res_d = g_stage[k-1].res;
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q   <= '0;
          b_q   <= '0;
          res_q <= '0;
        end else if (advance) begin
          a_q   <= a_d;
          b_q   <= b_d;
          res_q <= res_d;
        end
      end

      assign a_in = a_q;
      assign b_in = b_q;
      assign res  = {diff, res_q};
    end
  end

  assign res_full = g_stage[NSTAGES-1].res;
  assign data_o   = res_full[RW-1:0];
  assign valid_o  = vld[NSTAGES];

  // Padding bits above RW and the final borrow carry no information.
  assign unused_ok = borrow[NSTAGES] ^ (^(res_full >> RW));

endmodule

// File: tb/tb_pipelined_subtractor.sv
// Randomised and directed bench for pipelined_subtractor, checked against a
// queue-based transaction model (result arithmetic + advancing-cycle age).
module tb_pipelined_subtractor;

  localparam int unsigned NS  = 3;
  localparam int unsigned MOD = 32'h2_0000;

  typedef struct {
    logic [16:0] exp_a;
    logic [16:0] exp_b;
    int unsigned adv;
  } entry_t;

  typedef struct {
    logic [15:0] d1;
    logic [15:0] d2a;
    logic [7:0]  d2b;
    logic [16:0] ea;
    logic [16:0] eb;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, valid_i, ready_i;
  logic [15:0] data1_i, data2a;
  logic [7:0]  data2b;
  logic        ready_a, valid_a, ready_b, valid_b;
  logic [16:0] data_a, data_b;

  pipelined_subtractor u_dut_a (
    .clk     (clk),
    .rst     (rst),
    .data1_i (data1_i),
    .data2_i (data2a),
    .valid_i (valid_i),
    .ready_o (ready_a),
    .data_o  (data_a),
    .valid_o (valid_a),
    .ready_i (ready_i)
  );

  pipelined_subtractor #(
    .DATA_WIDTH_1(16),
    .DATA_WIDTH_2(8),
    .CHUNK_WIDTH (8)
  ) u_dut_b (
    .clk     (clk),
    .rst     (rst),
    .data1_i (data1_i),
    .data2_i (data2b),
    .valid_i (valid_i),
    .ready_o (ready_b),
    .data_o  (data_b),
    .valid_o (valid_b),
    .ready_i (ready_i)
  );

  always #5 clk = ~clk;

  entry_t      sb[$];
  int unsigned adv_cnt;
  logic        rst_seen;
  int unsigned n_checks;
  int unsigned n_errors;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] ref_sub(input int unsigned a, input int unsigned b);
    return 17'((a + MOD - b) % MOD);
  endfunction

  // One clock: drive inputs, check outputs at the negedge against the model,
  // update the model for the transfers that happen at the next posedge.
  task automatic step(input logic v, input logic [15:0] d1, input logic [15:0] d2a,
                      input logic [7:0] d2b, input logic rdy, input logic r,
                      input logic lit, input logic [16:0] la, input logic [16:0] lb,
                      output logic acc);
    logic   exp_v, exp_adv;
    entry_t e;
    rst = r; valid_i = v; data1_i = d1; data2a = d2a; data2b = d2b; ready_i = rdy;
    acc = 1'b0;
    @(negedge clk);
    if (rst_seen) begin
      check_eq("rst_valid_a", valid_a, 1'b0);
      check_eq("rst_valid_b", valid_b, 1'b0);
      check_eq("rst_data_a", data_a, 17'h0);
      check_eq("rst_data_b", data_b, 17'h0);
    end
    if (r) begin
      check_eq("rst_ready_a", ready_a, 1'b0);
      check_eq("rst_ready_b", ready_b, 1'b0);
      sb.delete();
    end else begin
      exp_v   = (sb.size() != 0) && (adv_cnt - sb[0].adv == NS);
      exp_adv = !exp_v || rdy;
      check_eq("valid_a", valid_a, exp_v);
      check_eq("valid_b", valid_b, exp_v);
      check_eq("ready_a", ready_a, exp_adv);
      check_eq("ready_b", ready_b, exp_adv);
      if (exp_v) begin
        check_eq("data_a", data_a, sb[0].exp_a);
        check_eq("data_b", data_b, sb[0].exp_b);
        if (rdy) void'(sb.pop_front());
      end
      if (v && exp_adv) begin
        e.exp_a = lit ? la : ref_sub(d1, d2a);
        e.exp_b = lit ? lb : ref_sub(d1, d2b);
        e.adv   = adv_cnt;
        sb.push_back(e);
        acc = 1'b1;
      end
      if (exp_adv) adv_cnt++;
    end
    rst_seen = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic r);
    logic acc;
    step(1'b0, '0, '0, '0, 1'b1, r, 1'b0, '0, '0, acc);
  endtask

  task automatic push_op(input logic [15:0] d1, input logic [15:0] d2a, input logic [7:0] d2b,
                         input logic [16:0] ea, input logic [16:0] eb);
    logic acc = 1'b0;
    for (int unsigned t = 0; t < 50 && !acc; t++)
      step(1'b1, d1, d2a, d2b, 1'b1, 1'b0, 1'b1, ea, eb, acc);
    check_eq("accept_to", acc, 1'b1);
  endtask

  task automatic drain();
    for (int unsigned t = 0; t < 50 && sb.size() != 0; t++) idle(1'b0);
    check_eq("drain", sb.size(), 0);
  endtask

  task automatic backpressure();
    int unsigned sent = 0;
    logic        acc;
    for (int unsigned c = 0; c < 40 && sent < 6; c++) begin
      step(1'b1, 16'($urandom), 16'($urandom), 8'($urandom), !(c >= 4 && c < 8),
           1'b0, 1'b0, '0, '0, acc);
      if (acc) sent++;
    end
    check_eq("bp_sent", sent, 6);
    drain();
  endtask

  vec_t vecs[5];

  initial begin
    logic acc;
    rst_seen = 1'b0; adv_cnt = 0; n_checks = 0; n_errors = 0;
    vecs[0] = '{16'h2234, 16'h52F2, 8'hF2, 17'h1CF42, 17'h02142};
    vecs[1] = '{16'h0000, 16'hFFFF, 8'hFF, 17'h10001, 17'h1FF01};
    vecs[2] = '{16'hFFFF, 16'h0000, 8'h00, 17'h0FFFF, 17'h0FFFF};
    vecs[3] = '{16'h0100, 16'h0001, 8'hFF, 17'h000FF, 17'h00001};
    vecs[4] = '{16'h8000, 16'h0001, 8'h01, 17'h07FFF, 17'h07FFF};

    idle(1'b1);
    idle(1'b1);

    push_op(16'h52F2, 16'h3671, 8'h71, 17'h01C81, 17'h05281);
    drain();

    foreach (vecs[i]) push_op(vecs[i].d1, vecs[i].d2a, vecs[i].d2b, vecs[i].ea, vecs[i].eb);
    drain();

    backpressure();

    push_op(16'h1234, 16'h0234, 8'h34, 17'h01000, 17'h01200);
    push_op(16'h0001, 16'h0002, 8'h02, 17'h1FFFF, 17'h1FFFF);
    step(1'b1, 16'h4444, 16'h1111, 8'h11, 1'b1, 1'b1, 1'b0, '0, '0, acc);
    push_op(16'hABCD, 16'h0BCD, 8'hCD, 17'h0A000, 17'h0AB00);
    drain();

    for (int unsigned n = 0; n < 400; n++)
      step($urandom_range(3) != 0, 16'($urandom), 16'($urandom), 8'($urandom),
           $urandom_range(3) != 0, $urandom_range(63) == 0, 1'b0, '0, '0, acc);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end

endmodule
